trackball_source_arbiter: RTL and testbench

//  Shares the trackball movement generator between two motion sources: PS/2 mouse packets and

---
 rtl/trackball_source_arbiter.sv | 114 +++++++++++
 tb/tb_trackball_source_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trackball_source_arbiter.sv
// Arbitrates the trackball packet stream between PS/2 mouse packets and joystick-generated
// synthetic packets; the mouse always wins, the joystick only owns the stream after mouse silence.
module trackball_source_arbiter #(
  parameter logic [15:0] PKT_PERIOD = 16'd40000,
  parameter logic [7:0]  HOLD_PKTS  = 8'd60,
  parameter logic [7:0]  JOY_MIN    = 8'd2,
  parameter logic [7:0]  JOY_MAX    = 8'd32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [24:0] ps2_mouse_in,
  input  logic        joy_up,
  input  logic        joy_down,
  input  logic        joy_left,
  input  logic        joy_right,
  input  logic        enable_joy,
  output logic [24:0] ps2_mouse_out,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MOUSE = 2'b01,
    JOY   = 2'b10
  } owner_t;

  owner_t      state_reg, state_next;
  logic [24:0] out_reg, out_next;
  logic [15:0] tick_cnt_reg;
  logic [7:0]  silence_reg, silence_next, silence_inc;
  logic [7:0]  mag_reg, mag_next, mag_inc;
  logic        old_toggle_reg, primed_reg;
  logic        tick, mouse_pkt, joy_any, x_neg, y_neg;
  logic [7:0]  joy_x, joy_y;

  assign tick      = (tick_cnt_reg == PKT_PERIOD - 16'd1);
  assign mouse_pkt = primed_reg && (ps2_mouse_in[24] != old_toggle_reg);
  assign joy_any   = joy_up || joy_down || joy_left || joy_right;

  // Opposing directions cancel to zero on that axis.
  assign x_neg = joy_left && !joy_right;
  assign y_neg = joy_down && !joy_up;
  assign joy_x = (joy_right && !joy_left) ? mag_reg : x_neg ? (8'd0 - mag_reg) : 8'd0;
  assign joy_y = (joy_up && !joy_down)    ? mag_reg : y_neg ? (8'd0 - mag_reg) : 8'd0;

  assign mag_inc     = (mag_reg >= JOY_MAX) ? JOY_MAX : mag_reg + 8'd1;
  assign silence_inc = (silence_reg == 8'hFF) ? silence_reg : silence_reg + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      out_reg        <= '0;
      tick_cnt_reg   <= '0;
      silence_reg    <= '0;
      mag_reg        <= JOY_MIN;
      old_toggle_reg <= 1'b0;
      primed_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      out_reg        <= out_next;
      tick_cnt_reg   <= tick ? 16'd0 : tick_cnt_reg + 16'd1;
      silence_reg    <= silence_next;
      mag_reg        <= mag_next;
      old_toggle_reg <= ps2_mouse_in[24];
      primed_reg     <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    out_next     = out_reg;
    silence_next = silence_reg;
    mag_next     = mag_reg;
    if (mouse_pkt) begin
      // Mouse preempts everything, including a coincident synthetic tick.
      out_next     = {~out_reg[24], ps2_mouse_in[23:0]};
      silence_next = 8'd0;
      mag_next     = JOY_MIN;
      state_next   = MOUSE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable_joy && joy_any) state_next = JOY;
        end
        MOUSE: begin
          if (tick) begin
            silence_next = silence_inc;
            if (silence_inc >= HOLD_PKTS) state_next = IDLE;
          end
        end
        JOY: begin
          if (!enable_joy) begin
            // Restart the ramp so a later press begins at the minimum magnitude.
            state_next = IDLE;
            mag_next   = JOY_MIN;
          end else if (tick) begin
            if (joy_any) begin
              out_next = {~out_reg[24], joy_y, joy_x, 2'b00, y_neg, x_neg, 1'b1, 3'b000};
              mag_next = mag_inc;
            end else begin
              state_next = IDLE;
              mag_next   = JOY_MIN;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign ps2_mouse_out = out_reg;
  assign owner         = state_reg;

endmodule

// File: tb/tb_trackball_source_arbiter.sv
// Directed bench for trackball_source_arbiter using a short packet period so hold-off fits in a short run.
module tb_trackball_source_arbiter;

  localparam int P = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [24:0] ps2_mouse_in = '0;
  logic        joy_up = 1'b0, joy_down = 1'b0, joy_left = 1'b0, joy_right = 1'b0;
  logic        enable_joy = 1'b0;
  logic [24:0] ps2_mouse_out;
  logic [1:0]  owner;

  int   checks = 0;
  int   errors = 0;
  int   cyc;
  logic in_tog = 1'b0;
  logic exp_tog = 1'b0;
  logic [24:0] exp_pkt;

  trackball_source_arbiter #(
    .PKT_PERIOD(16'd20),
    .HOLD_PKTS (8'd60),
    .JOY_MIN   (8'd2),
    .JOY_MAX   (8'd32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ps2_mouse_in (ps2_mouse_in),
    .joy_up       (joy_up),
    .joy_down     (joy_down),
    .joy_left     (joy_left),
    .joy_right    (joy_right),
    .enable_joy   (enable_joy),
    .ps2_mouse_out(ps2_mouse_out),
    .owner        (owner)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; the upcoming edge is a tick when cyc % P == P-1.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Called at a negedge; returns at the negedge just after the next tick edge.
  task automatic wait_tick();
    int n = 0;
    while ((cyc % P) != P - 1 && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * P) begin
      checks++; errors++;
      $display("FAIL wait_tick: no tick within %0d cycles (got cyc=%0d, required tick)", 2 * P, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_tog = 1'b1;
    ps2_mouse_in = {in_tog, 24'h0};
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (ps2_mouse_out !== 25'h0) begin
      errors++; $display("FAIL reset_out: got %h expected %h", ps2_mouse_out, 25'h0);
    end else $display("check reset_out ok %h", ps2_mouse_out);
    checks++;
    if (owner !== 2'b00) begin
      errors++; $display("FAIL reset_owner: got %b expected %b", owner, 2'b00);
    end else $display("check reset_owner ok %b", owner);
  endtask

  task automatic test_mouse();
    in_tog = ~in_tog;
    ps2_mouse_in = {in_tog, 8'h00, 8'h05, 8'h00};
    @(negedge clk);
    exp_tog = ~exp_tog;
    exp_pkt = {exp_tog, 24'h000500};
    checks++;
    if (ps2_mouse_out !== exp_pkt || owner !== 2'b01) begin
      errors++; $display("FAIL mouse_fwd: got %h/%b expected %h/01", ps2_mouse_out, owner, exp_pkt);
    end else $display("check mouse_fwd ok %h owner %b", ps2_mouse_out, owner);
    repeat (59) wait_tick();
    checks++;
    if (owner !== 2'b01) begin
      errors++; $display("FAIL mouse_hold59: got %b expected %b", owner, 2'b01);
    end else $display("check mouse_hold59 ok %b", owner);
    wait_tick();
    checks++;
    if (owner !== 2'b00) begin
      errors++; $display("FAIL mouse_lapse60: got %b expected %b", owner, 2'b00);
    end else $display("check mouse_lapse60 ok %b", owner);
  endtask

  task automatic test_joy_ramp();
    enable_joy = 1'b1;
    joy_right = 1'b1;
    @(negedge clk);
    checks++;
    if (owner !== 2'b10) begin
      errors++; $display("FAIL ramp_owner: got %b expected %b", owner, 2'b10);
    end else $display("check ramp_owner ok %b", owner);
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      exp_tog = ~exp_tog;
      exp_pkt = {exp_tog, 8'h00, 8'(2 + i), 8'h08};
      checks++;
      if (ps2_mouse_out !== exp_pkt) begin
        errors++; $display("FAIL ramp_pkt%0d: got %h expected %h", i, ps2_mouse_out, exp_pkt);
      end else $display("check ramp_pkt%0d ok %h", i, ps2_mouse_out);
    end
    joy_right = 1'b0;
    wait_tick();
    checks++;
    if (owner !== 2'b00) begin
      errors++; $display("FAIL ramp_release_owner: got %b expected %b", owner, 2'b00);
    end else $display("check ramp_release_owner ok %b", owner);
    checks++;
    if (ps2_mouse_out[24] !== exp_tog) begin
      errors++; $display("FAIL ramp_release_nopkt: got %b expected %b", ps2_mouse_out[24], exp_tog);
    end else $display("check ramp_release_nopkt ok %b", ps2_mouse_out[24]);
  endtask

  task automatic test_joy_dir(input string name, input logic u, input logic d, input logic l,
                              input logic r, input logic [7:0] ey, input logic [7:0] ex,
                              input logic [7:0] elo);
    joy_up = u; joy_down = d; joy_left = l; joy_right = r;
    @(negedge clk);
    checks++;
    if (owner !== 2'b10) begin
      errors++; $display("FAIL %s_owner: got %b expected %b", name, owner, 2'b10);
    end else $display("check %s_owner ok %b", name, owner);
    wait_tick();
    exp_tog = ~exp_tog;
    exp_pkt = {exp_tog, ey, ex, elo};
    checks++;
    if (ps2_mouse_out !== exp_pkt) begin
      errors++; $display("FAIL %s_pkt: got %h expected %h", name, ps2_mouse_out, exp_pkt);
    end else $display("check %s_pkt ok %h", name, ps2_mouse_out);
    joy_up = 1'b0; joy_down = 1'b0; joy_left = 1'b0; joy_right = 1'b0;
    wait_tick();
    checks++;
    if (owner !== 2'b00) begin
      errors++; $display("FAIL %s_idle: got %b expected %b", name, owner, 2'b00);
    end else $display("check %s_idle ok %b", name, owner);
  endtask

  task automatic test_joy_disable();
    joy_right = 1'b1;
    @(negedge clk);
    wait_tick();
    exp_tog = ~exp_tog;
    exp_pkt = {exp_tog, 8'h00, 8'h02, 8'h08};
    checks++;
    if (ps2_mouse_out !== exp_pkt) begin
      errors++; $display("FAIL disable_pkt: got %h expected %h", ps2_mouse_out, exp_pkt);
    end else $display("check disable_pkt ok %h", ps2_mouse_out);
    enable_joy = 1'b0;
    @(negedge clk);
    checks++;
    if (owner !== 2'b00) begin
      errors++; $display("FAIL disable_owner: got %b expected %b", owner, 2'b00);
    end else $display("check disable_owner ok %b", owner);
    wait_tick();
    checks++;
    if (ps2_mouse_out !== exp_pkt) begin
      errors++; $display("FAIL disable_nopkt: got %h expected %h", ps2_mouse_out, exp_pkt);
    end else $display("check disable_nopkt ok %h", ps2_mouse_out);
    joy_right = 1'b0;
    enable_joy = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mouse_preempt();
    int n = 0;
    joy_right = 1'b1;
    @(negedge clk);
    checks++;
    if (owner !== 2'b10) begin
      errors++; $display("FAIL preempt_joy_owner: got %b expected %b", owner, 2'b10);
    end else $display("check preempt_joy_owner ok %b", owner);
    while ((cyc % P) != P - 1 && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    in_tog = ~in_tog;
    ps2_mouse_in = {in_tog, 8'h00, 8'h11, 8'h00};
    @(negedge clk);
    exp_tog = ~exp_tog;
    exp_pkt = {exp_tog, 24'h001100};
    checks++;
    if (ps2_mouse_out !== exp_pkt || owner !== 2'b01) begin
      errors++; $display("FAIL preempt_pkt: got %h/%b expected %h/01", ps2_mouse_out, owner, exp_pkt);
    end else $display("check preempt_pkt ok %h owner %b", ps2_mouse_out, owner);
    repeat (2 * P) @(negedge clk);
    checks++;
    if (ps2_mouse_out !== exp_pkt || owner !== 2'b01) begin
      errors++; $display("FAIL preempt_single: got %h/%b expected %h/01", ps2_mouse_out, owner, exp_pkt);
    end else $display("check preempt_single ok %h owner %b", ps2_mouse_out, owner);
    joy_right = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_tog = 1'b0;
    enable_joy = 1'b1;
    joy_right = 1'b1;
    @(negedge clk);
    wait_tick();
    exp_pkt = {1'b1, 8'h00, 8'h02, 8'h08};
    checks++;
    if (ps2_mouse_out !== exp_pkt || owner !== 2'b10) begin
      errors++; $display("FAIL midreset_pre: got %h/%b expected %h/10", ps2_mouse_out, owner, exp_pkt);
    end else $display("check midreset_pre ok %h owner %b", ps2_mouse_out, owner);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ps2_mouse_out !== 25'h0) begin
      errors++; $display("FAIL midreset_out: got %h expected %h", ps2_mouse_out, 25'h0);
    end else $display("check midreset_out ok %h", ps2_mouse_out);
    checks++;
    if (owner !== 2'b00) begin
      errors++; $display("FAIL midreset_owner: got %b expected %b", owner, 2'b00);
    end else $display("check midreset_owner ok %b", owner);
    joy_right = 1'b0;
    enable_joy = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * P) @(negedge clk);
    checks++;
    if (ps2_mouse_out !== 25'h0 || owner !== 2'b00) begin
      errors++; $display("FAIL midreset_quiet: got %h/%b expected %h/00", ps2_mouse_out, owner, 25'h0);
    end else $display("check midreset_quiet ok %h owner %b", ps2_mouse_out, owner);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mouse();
    test_joy_ramp();
    test_joy_dir("restart",   1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h02, 8'h08);
    test_joy_dir("left_up",   1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 8'hFE, 8'h18);
    test_joy_dir("left_right",1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h08);
    test_joy_disable();
    test_mouse_preempt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
